lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Load/store unit between the single-cycle core and a handshaked data-memory bus.
- Produces the load-data word RD, which feeds the writeback ResultSrc selection (ResultSrc=01).
- Drives the memory bus for stores.
- Stalls the core (PC and register-file write enable gated by Stall) until the bus transaction completes, times out, or is rejected.

Parameters:
- TIMEOUT, 16, max cycles mem_req may wait for mem_ready before abort (range 1..255).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- MemRead  in  1  current instruction is a load
- MemWrite  in  1  current instruction is a store
- ALUResult  in  32  effective byte address
- WriteData  in  32  store data (rs2)
- Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- RD  out  32  extended load data, registered
- Stall  out  1  core must hold PC and suppress writeback
- BusErr  out  1  one-cycle pulse on timeout or misalignment trap
- mem_req  out  1  bus request, held until mem_ready
- mem_we  out  1  1 = write
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  store data lane-shifted
- mem_be  out  4  byte enables
- mem_ready  in  1  bus accepts/completes request this cycle
- mem_rdata  in  32  read word, valid when mem_ready & ~mem_we

Behaviour:
- Reset values (asynchronous, immediate): state IDLE; RD=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; mem_be=0; BusErr=0; timeout counter 0.
- Stall is forced to 0 while reset is high.
- States: IDLE, REQ, DONE.
- IDLE:
  - If MemRead|MemWrite: latch address, Funct3, write flag and shifted wdata/be; go to REQ.
  - Stall = MemRead|MemWrite, combinational in IDLE, so it asserts in the request cycle.
  - If MemRead and MemWrite are both asserted, the access is a write.
- REQ:
  - mem_req=1; bus outputs stable for the whole state.
  - Counter increments each cycle.
  - mem_ready=1: capture and extend mem_rdata into RD (loads only; stores leave RD unchanged); go to DONE.
  - Counter reaches TIMEOUT without mem_ready: drop mem_req, RD=0, BusErr=1 for one cycle, go to DONE.
  - Stall=1 throughout.
- DONE:
  - Stall=0 for exactly one cycle; the core commits writeback (RD valid) at this edge.
  - Next state IDLE unconditionally; a new access is recognised only from IDLE.
  - Minimum access latency: request cycle + 1 REQ cycle, then DONE. Zero-wait memory gives Stall high for 2 cycles.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{WriteData[7:0]}}.
  - SH: be=0011<<{addr[1],1'b0}, wdata={2{WriteData[15:0]}}.
  - SW: be=1111, wdata=WriteData.
- Load extraction:
  - B/BU: select byte addr[1:0], sign-/zero-extend.
  - H/HU: select half addr[1], sign-/zero-extend.
  - W: whole word.
  - Undefined Funct3: RD=0 for loads; for stores it is treated as SW.
- Reset mid-transaction: mem_req falls asynchronously, the transaction is abandoned, and no BusErr is raised.
- mem_ready outside REQ is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - H access with addr[0]=1, or W access with addr[1:0]≠0, issues no bus request.
  - IDLE goes to DONE directly (Stall high 1 cycle), with BusErr=1 and RD=0.
- Undefined:
  - Misaligned low bits are ignored: H uses addr[1] only, W uses the aligned word.
  - BusErr is raised only by timeout.

Test Plan:
- LW addr 0x100, mem_ready immediate, mem_rdata 0xDEADBEEF -> mem_addr 0x100, Stall 2 cycles, RD=0xDEADBEEF in DONE, BusErr 0.
- LB addr 0x203, rdata 0x80112233 -> RD=0xFFFFFF80; same with LBU -> RD=0x00000080; LHU addr 0x202 -> RD=0x00008011.
- SB addr 0x7, WriteData 0x000000A5 -> mem_addr 0x4, mem_be 1000, mem_wdata 0xA5A5A5A5, mem_we 1; SH addr 0x6 -> be 1100.
- mem_ready withheld, TIMEOUT=16 -> mem_req high 16 cycles then low, BusErr pulses once, RD=0, Stall releases the following DONE cycle.
- Reset asserted during REQ with 3 wait cycles -> mem_req, Stall, BusErr 0 immediately; after release, a fresh LW completes normally.
- With LSU_MISALIGN_TRAP_EN, LW addr 0x102 -> no mem_req, BusErr 1, Stall 1 cycle; without it -> mem_addr 0x100, normal read.

Source files
------------

// File: rtl/lsu_mem_port_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// The request side is held stable by the master until mem_ready.
interface lsu_mem_port_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit between the single-cycle core and a handshaked data bus.
// Stalls the core from the request cycle until the access completes, times
// out after TIMEOUT cycles, or (optionally) is trapped as misaligned.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// H/W accesses skip the bus and raise BusErr directly.
module lsu_mem_port #(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [31:0]           ALUResult,
    input  logic [31:0]           WriteData,
    input  logic [2:0]            Funct3,
    output logic [31:0]           RD,
    output logic                  Stall,
    output logic                  BusErr,
    lsu_mem_port_if.master        bus
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] rd_q, rd_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lo_q, lo_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic        misalign;
    logic [7:0]  cnt_inc;

    // Sign/zero-extend the addressed byte or half of the returned word.
    function automatic logic [31:0] load_ext(input logic [2:0] f3,
                                             input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return w;
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

    // Store lane steering; loads request the full word, undefined sizes store as SW.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = 32'h0;
        if (MemWrite) begin
            case (Funct3)
                3'b000: begin
                    st_be    = 4'b0001 << ALUResult[1:0];
                    st_wdata = {4{WriteData[7:0]}};
                end
                3'b001: begin
                    st_be    = 4'b0011 << {ALUResult[1], 1'b0};
                    st_wdata = {2{WriteData[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = WriteData;
                end
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned half/word detection; stores use their effective (SW-default) size.
    always_comb begin
        misalign = 1'b0;
        if (MemWrite) begin
            case (Funct3)
                3'b000:  misalign = 1'b0;
                3'b001:  misalign = ALUResult[0];
                default: misalign = |ALUResult[1:0];
            endcase
        end else begin
            case (Funct3)
                3'b001, 3'b101: misalign = ALUResult[0];
                3'b010:         misalign = |ALUResult[1:0];
                default:        misalign = 1'b0;
            endcase
        end
    end
`else
    assign misalign = 1'b0;
`endif

    assign cnt_inc = cnt_q + 8'd1;

    // Next-state and datapath updates for the IDLE/REQ/DONE sequencer.
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemRead | MemWrite) begin
                    if (misalign) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rd_d    = 32'h0;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = MemWrite;
                        addr_d  = {ALUResult[31:2], 2'b00};
                        wdata_d = st_wdata;
                        be_d    = st_be;
                        f3_d    = Funct3;
                        lo_d    = ALUResult[1:0];
                        cnt_d   = 8'd0;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_inc;
                if (bus.mem_ready) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q)
                        rd_d = load_ext(f3_q, lo_q, bus.mem_rdata);
                end else if (cnt_inc == TO) begin
                    req_d   = 1'b0;
                    rd_d    = 32'h0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any transaction silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rd_q    <= 32'h0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            f3_q    <= 3'h0;
            lo_q    <= 2'h0;
            cnt_q   <= 8'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Stall rises combinationally in the request cycle so the PC holds immediately.
    assign Stall = ~reset & (((state_q == IDLE) & (MemRead | MemWrite)) | (state_q == REQ));

    assign RD            = rd_q;
    assign BusErr        = err_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: table of zero-wait accesses plus
// hand-written timeout, reset-abort, ready-outside-REQ and misalign cases.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] ALUResult, WriteData;
    logic [2:0]  Funct3;
    logic [31:0] RD;
    logic        Stall, BusErr;

    int n_pass = 0;
    int n_tot  = 0;

    lsu_mem_port_if bus();

    lsu_mem_port #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .Funct3    (Funct3),
        .RD        (RD),
        .Stall     (Stall),
        .BusErr    (BusErr),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_rd;
    } vec_t;

    function automatic vec_t mkv(logic rd, logic wr, logic [2:0] f3,
                                 logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                                 logic [31:0] e_addr, logic e_we, logic [3:0] e_be,
                                 logic [31:0] e_wdata, logic [31:0] e_rd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.e_addr = e_addr; v.e_we = e_we; v.e_be = e_be; v.e_wdata = e_wdata; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    endtask

    // One zero-wait access: request cycle, one REQ cycle, then DONE.
    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        MemRead = v.rd; MemWrite = v.wr; Funct3 = v.f3;
        ALUResult = v.addr; WriteData = v.wdata;
        #1 chk("stall_reqcyc", idx, 32'(Stall), 32'd1);
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        chk("mem_req", idx, 32'(bus.mem_req), 32'd1);
        chk("stall_req", idx, 32'(Stall), 32'd1);
        chk("mem_addr", idx, bus.mem_addr, v.e_addr);
        chk("mem_we", idx, 32'(bus.mem_we), 32'(v.e_we));
        if (v.wr) begin
            chk("mem_be", idx, 32'(bus.mem_be), 32'(v.e_be));
            chk("mem_wdata", idx, bus.mem_wdata, v.e_wdata);
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = v.rdata;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        @(negedge clk);
        chk("stall_done", idx, 32'(Stall), 32'd0);
        chk("req_done", idx, 32'(bus.mem_req), 32'd0);
        chk("buserr_done", idx, 32'(BusErr), 32'd0);
        chk("rd_done", idx, RD, v.e_rd);
    endtask

    vec_t vt[12];

    initial begin
        int hi, early_err;
        bit seen;

        vt[0]  = mkv(1,0,3'b010,32'h100,32'h0,32'hDEADBEEF, 32'h100,0,4'h0,32'h0,32'hDEADBEEF);
        vt[1]  = mkv(1,0,3'b000,32'h203,32'h0,32'h80112233, 32'h200,0,4'h0,32'h0,32'hFFFFFF80);
        vt[2]  = mkv(1,0,3'b100,32'h203,32'h0,32'h80112233, 32'h200,0,4'h0,32'h0,32'h00000080);
        vt[3]  = mkv(1,0,3'b101,32'h202,32'h0,32'h80112233, 32'h200,0,4'h0,32'h0,32'h00008011);
        vt[4]  = mkv(1,0,3'b001,32'h202,32'h0,32'h80112233, 32'h200,0,4'h0,32'h0,32'hFFFF8011);
        vt[5]  = mkv(1,0,3'b000,32'h200,32'h0,32'h80112233, 32'h200,0,4'h0,32'h0,32'h00000033);
        vt[6]  = mkv(0,1,3'b000,32'h7,32'h000000A5,32'h0, 32'h4,1,4'b1000,32'hA5A5A5A5,32'h33);
        vt[7]  = mkv(0,1,3'b001,32'h6,32'h1234BEEF,32'h0, 32'h4,1,4'b1100,32'hBEEFBEEF,32'h33);
        vt[8]  = mkv(0,1,3'b010,32'h10,32'h12345678,32'h0, 32'h10,1,4'b1111,32'h12345678,32'h33);
        vt[9]  = mkv(1,1,3'b000,32'h31,32'h0000005A,32'h11111111, 32'h30,1,4'b0010,32'h5A5A5A5A,32'h33);
        vt[10] = mkv(1,0,3'b011,32'h20,32'h0,32'hFFFFFFFF, 32'h20,0,4'h0,32'h0,32'h0);
        vt[11] = mkv(0,1,3'b011,32'h24,32'hCAFEF00D,32'h0, 32'h24,1,4'b1111,32'hCAFEF00D,32'h0);

        // Reset state; MemRead held high to show Stall is forced low.
        reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
        ALUResult = 32'h0; WriteData = 32'h0; Funct3 = 3'b010;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        #2;
        chk("rst_stall", 0, 32'(Stall), 32'd0);
        chk("rst_req", 0, 32'(bus.mem_req), 32'd0);
        chk("rst_rd", 0, RD, 32'h0);
        chk("rst_addr", 0, bus.mem_addr, 32'h0);
        chk("rst_be", 0, 32'(bus.mem_be), 32'd0);
        chk("rst_buserr", 0, 32'(BusErr), 32'd0);
        MemRead = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vt[i], i);

        // mem_ready pulsed while idle must not touch RD.
        run_vec(mkv(1,0,3'b010,32'h50,32'h0,32'h13579BDF, 32'h50,0,4'h0,32'h0,32'h13579BDF), 20);
        @(negedge clk);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFF0000;
        @(negedge clk);
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        chk("idle_ready_rd", 21, RD, 32'h13579BDF);
        chk("idle_ready_req", 21, 32'(bus.mem_req), 32'd0);

        // Misaligned word load.
`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk);
        MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h102;
        #1 chk("mis_stall_req", 30, 32'(Stall), 32'd1);
        @(posedge clk); #1; MemRead = 1'b0;
        @(negedge clk);
        chk("mis_req", 30, 32'(bus.mem_req), 32'd0);
        chk("mis_buserr", 30, 32'(BusErr), 32'd1);
        chk("mis_stall", 30, 32'(Stall), 32'd0);
        chk("mis_rd", 30, RD, 32'h0);
        @(negedge clk);
        chk("mis_buserr_clr", 30, 32'(BusErr), 32'd0);
`else
        run_vec(mkv(1,0,3'b010,32'h102,32'h0,32'h600DCAFE, 32'h100,0,4'h0,32'h0,32'h600DCAFE), 30);
`endif

        // Timeout: mem_ready never comes.
        run_vec(mkv(1,0,3'b010,32'h44,32'h0,32'h55AA55AA, 32'h44,0,4'h0,32'h0,32'h55AA55AA), 40);
        @(negedge clk);
        MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h40;
        @(posedge clk); #1; MemRead = 1'b0;
        hi = 0; early_err = 0; seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                hi++;
                if (BusErr) early_err++;
            end else seen = 1'b1;
        end
        chk("to_seen", 41, 32'(seen), 32'd1);
        chk("to_req_cycles", 41, 32'(hi), 32'd16);
        chk("to_early_err", 41, 32'(early_err), 32'd0);
        chk("to_buserr", 41, 32'(BusErr), 32'd1);
        chk("to_stall", 41, 32'(Stall), 32'd0);
        chk("to_rd", 41, RD, 32'h0);
        @(negedge clk);
        chk("to_buserr_clr", 41, 32'(BusErr), 32'd0);

        // Reset during REQ after 3 wait cycles.
        @(negedge clk);
        MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h80;
        @(posedge clk); #1; MemRead = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_req_before", 50, 32'(bus.mem_req), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid_req", 50, 32'(bus.mem_req), 32'd0);
        chk("mid_stall", 50, 32'(Stall), 32'd0);
        chk("mid_buserr", 50, 32'(BusErr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_buserr_after", 50, 32'(BusErr), 32'd0);
        run_vec(mkv(1,0,3'b010,32'h84,32'h0,32'h0BADF00D, 32'h84,0,4'h0,32'h0,32'h0BADF00D), 51);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
